// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp codes and lamp decode for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_A = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED_B = 3'd5
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  // Packed as {main_rgy, side_rgy, ped_walk}; anything unknown shows all-red.
  function automatic logic [6:0] decode_lights(state_t s);
    case (s)
      MAIN_G:  return {LIGHT_GREEN,  LIGHT_RED,    1'b0};
      MAIN_Y:  return {LIGHT_YELLOW, LIGHT_RED,    1'b0};
      SIDE_G:  return {LIGHT_RED,    LIGHT_GREEN,  1'b1};
      SIDE_Y:  return {LIGHT_RED,    LIGHT_YELLOW, 1'b0};
      default: return {LIGHT_RED,    LIGHT_RED,    1'b0};
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter of tick strobes within one phase; done flags the phase-ending cycle.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] dur,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && count < dur) begin
      count <= count + W'(1);
    end
  end

  // Either this tick completes the duration, or it already completed earlier (held main green).
  assign done = (tick && count >= dur - W'(1)) || (count >= dur);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer with request latch and registered lamp outputs.
//   state    | meaning
//   MAIN_G   | main green, waits for GREEN_MIN and a request
//   MAIN_Y   | main yellow
//   ALLRED_A | clearance before side road
//   SIDE_G   | side green, walk lamp on
//   SIDE_Y   | side yellow
//   ALLRED_B | clearance before main road, reset state
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 8,
  parameter int SIDE_GREEN_T = 5,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       ped_walk,
  output logic [2:0] state_o
);

  localparam int MAX_AB  = (GREEN_MIN > SIDE_GREEN_T) ? GREEN_MIN : SIDE_GREEN_T;
  localparam int MAX_CD  = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int MAX_DUR = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_DUR) + 1;

  state_t        state;
  state_t        state_nxt;
  logic          pending;
  logic          illegal;
  logic          advance;
  logic          done;
  logic [TW-1:0] dur;

  phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (advance),
    .tick  (tick),
    .dur   (dur),
    .done  (done)
  );

  always_comb begin
    state_nxt = ALLRED_B;
    dur       = TW'(1);
    illegal   = 1'b0;
    case (state)
      MAIN_G:   begin dur = TW'(GREEN_MIN);    state_nxt = MAIN_Y;   end
      MAIN_Y:   begin dur = TW'(YELLOW_T);     state_nxt = ALLRED_A; end
      ALLRED_A: begin dur = TW'(ALLRED_T);     state_nxt = SIDE_G;   end
      SIDE_G:   begin dur = TW'(SIDE_GREEN_T); state_nxt = SIDE_Y;   end
      SIDE_Y:   begin dur = TW'(YELLOW_T);     state_nxt = ALLRED_B; end
      ALLRED_B: begin dur = TW'(ALLRED_T);     state_nxt = MAIN_G;   end
      default:  illegal = 1'b1;
    endcase
    // A request arriving on the yielding cycle itself still releases main green.
    advance = illegal | (done & ((state != MAIN_G) | pending | car_side | ped_req));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALLRED_B;
      pending  <= 1'b0;
      main_rgy <= LIGHT_RED;
      side_rgy <= LIGHT_RED;
      ped_walk <= 1'b0;
    end else begin
      if (advance) begin
        state <= state_nxt;
      end
      {main_rgy, side_rgy, ped_walk} <= decode_lights(advance ? state_nxt : state);
      if (advance && state_nxt == SIDE_G) begin
        pending <= 1'b0;
      end else if (car_side || ped_req) begin
        pending <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench: stimulus queues expected phase transitions, a negedge monitor checks them.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       car_side = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic       ped_walk;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;

  // st: state entered; ticks: ticks spent in the phase just left (-1 = don't care);
  // on_tick: whether the change happened on a tick edge.
  typedef struct {
    int st;
    int ticks;
    int on_tick;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .GREEN_MIN    (4),
    .SIDE_GREEN_T (3),
    .YELLOW_T     (2),
    .ALLRED_T     (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .car_side (car_side),
    .ped_req  (ped_req),
    .main_rgy (main_rgy),
    .side_rgy (side_rgy),
    .ped_walk (ped_walk),
    .state_o  (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {main, side, walk} per state, straight from the lamp table.
  function automatic int lamp_ref(input int st);
    case (st)
      0:       return 7'b010_100_0;
      1:       return 7'b001_100_0;
      2:       return 7'b100_100_0;
      3:       return 7'b100_010_1;
      4:       return 7'b100_001_0;
      5:       return 7'b100_100_0;
      default: return -1;
    endcase
  endfunction

  task automatic push(input int st, input int ticks, input int on_tick);
    exp_t e;
    e.st = st;
    e.ticks = ticks;
    e.on_tick = on_tick;
    sb.push_back(e);
  endtask

  // One full side-road service, starting from the exit of main green.
  task automatic push_pass(input int main_ticks, input int main_on_tick);
    push(int'(MAIN_Y), main_ticks, main_on_tick);
    push(int'(ALLRED_A), 2, 1);
    push(int'(SIDE_G), 1, 1);
    push(int'(SIDE_Y), 3, 1);
    push(int'(ALLRED_B), 2, 1);
    push(int'(MAIN_G), 1, 1);
  endtask

  task automatic cyc(input logic ped);
    @(posedge clk);
    #1;
    cnt++;
    tick = (cnt % 4 == 0);
    ped_req = ped;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic next_tick(input logic ped);
    for (int i = 0; i < 4 && ((cnt + 1) % 4) != 0; i++) cyc(1'b0);
    cyc(ped);
  endtask

  task automatic wait_main();
    for (int i = 0; i < 100 && state_o != MAIN_G; i++) cyc(1'b0);
    chk("reach_main_g", int'(state_o), int'(MAIN_G));
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) cyc(1'b0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle invariants plus scoreboard compare on every state change.
  initial begin : monitor
    int last_st;
    int phase_ticks;
    int prev_tick;
    exp_t e;
    last_st = int'(ALLRED_B);
    phase_ticks = 0;
    prev_tick = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_st = int'(ALLRED_B);
        phase_ticks = 0;
        prev_tick = 0;
      end else begin
        chk("onehot_main", int'($onehot(main_rgy)), 1);
        chk("onehot_side", int'($onehot(side_rgy)), 1);
        chk("both_non_red", int'(main_rgy != 3'b100 && side_rgy != 3'b100), 0);
        chk("walk_vs_state", int'(ped_walk), int'(state_o == SIDE_G));
        chk("lamps_vs_state", int'({main_rgy, side_rgy, ped_walk}), lamp_ref(int'(state_o)));
        if (int'(state_o) != last_st) begin
          if (sb.size() == 0) begin
            chk("unexpected_state_change", int'(state_o), last_st);
          end else begin
            e = sb.pop_front();
            chk("next_state", int'(state_o), e.st);
            if (e.ticks >= 0) chk("phase_ticks", phase_ticks, e.ticks);
            chk("change_on_tick", prev_tick, e.on_tick);
          end
          last_st = int'(state_o);
          phase_ticks = 0;
        end
        prev_tick = int'(tick);
        if (tick) phase_ticks++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), int'(ALLRED_B));
    chk("rst_main", int'(main_rgy), 3'b100);
    chk("rst_side", int'(side_rgy), 3'b100);
    chk("rst_walk", int'(ped_walk), 0);

    // No requests: main green after one tick, then rests there.
    rst_n = 1'b1;
    push(int'(MAIN_G), 1, 1);
    idle(60);
    chk("idle_drained", sb.size(), 0);
    chk("idle_main_g", int'(state_o), int'(MAIN_G));

    // Held (saturated) main green yields on the very next edge, even off-tick.
    for (int i = 0; i < 4 && ((cnt + 1) % 4) != 2; i++) cyc(1'b0);
    push_pass(-1, 0);
    cyc(1'b1);
    drain(200);
    idle(30);

    // Pedestrian on tick 1 of main green: full pass, then rest on green.
    reset_cycle();
    push(int'(MAIN_G), 1, 1);
    wait_main();
    push_pass(4, 1);
    next_tick(1'b1);
    drain(200);
    idle(60);
    chk("ped_rest_drained", sb.size(), 0);
    chk("ped_rest_main_g", int'(state_o), int'(MAIN_G));

    // Request on the tick that ends the 4th main-green tick, then reset mid side-green.
    reset_cycle();
    push(int'(MAIN_G), 1, 1);
    wait_main();
    next_tick(1'b0);
    next_tick(1'b0);
    next_tick(1'b0);
    push(int'(MAIN_Y), 4, 1);
    push(int'(ALLRED_A), 2, 1);
    push(int'(SIDE_G), 1, 1);
    next_tick(1'b1);
    drain(200);
    chk("in_side_g", int'(state_o), int'(SIDE_G));
    chk("walk_in_side_g", int'(ped_walk), 1);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_main", int'(main_rgy), 3'b100);
    chk("async_rst_side", int'(side_rgy), 3'b100);
    chk("async_rst_walk", int'(ped_walk), 0);
    chk("async_rst_state", int'(state_o), int'(ALLRED_B));
    cyc(1'b0);
    cyc(1'b0);
    rst_n = 1'b1;
    push(int'(MAIN_G), 1, 1);
    idle(80);
    chk("pending_discarded", sb.size(), 0);
    chk("post_rst_main_g", int'(state_o), int'(MAIN_G));

    // Side car held from reset: continuous cycling, main green exactly 4 ticks per pass.
    rst_n = 1'b0;
    car_side = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst_n = 1'b1;
    push(int'(MAIN_G), 1, 1);
    push_pass(4, 1);
    push_pass(4, 1);
    drain(400);
    car_side = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
